seven_seg_display: RTL and testbench

- Drives a 4-digit, common-anode, multiplexed seven-segment display from a 16-bit packed BCD value of 4 nibbles.
- Sits at the output of the frequency-counter datapath and takes the BCD-converted frequency reading.
- A free-running refresh counter scans the digits.
- Segment and anode outputs are active-low and registered.

---
 rtl/seven_seg_display.sv | 163 ++++++++++++++++
 tb/tb_seven_seg_display.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_display.sv
// ---------------------------------------------------------------------------
// seven_seg_display
//
// Purpose:
//   Drives a 4-digit, common-anode, multiplexed seven-segment display from a
//   16-bit packed BCD reading. The reading comes from the frequency-counter
//   datapath. A free-running refresh counter scans the digits, and its top
//   two bits select the digit. The segment and anode pins are active-low and
//   registered, so the pins lag the counter and BCDfreq by one clock.
//
// Parameters:
//   REFRESH_BITS : width of the refresh counter. It must be 3 or greater.
//                  Each digit stays lit for 2^(REFRESH_BITS-2) clocks, and a
//                  full scan takes 2^REFRESH_BITS clocks.
//
// Ports:
//   clk            rising-edge system clock
//   reset          asynchronous active-low reset (0 = in reset)
//   BCDfreq[15:0]  packed BCD value: [3:0] ones, [7:4] tens,
//                  [11:8] hundreds, [15:12] thousands. It is sampled live.
//   a..g           segment drives, active-low
//   dp             decimal point, active-low (always off)
//   enable[3:0]    digit anodes, active-low; enable[0] is the ones digit
//
// Optional feature (compile-time macro SEVSEG_LEADING_ZERO_BLANK_EN):
//   When the macro is defined, leading zeros on digits 3..1 are blanked.
//   A blanked digit keeps its anode slot but drives all segments off.
//   Digit 0 is never blanked.
// ---------------------------------------------------------------------------
module seven_seg_display #(
  parameter int REFRESH_BITS = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] BCDfreq,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        e,
  output logic        f,
  output logic        g,
  output logic        dp,
  output logic [3:0]  enable
);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  // Segment pattern for one nibble, packed as {a,b,c,d,e,f,g} and active-low.
  // A nibble outside 0-9 has no BCD meaning, so it shows a dash.
  function automatic logic [6:0] decode_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

  // Free-running scan counter.
  logic [REFRESH_BITS-1:0] refresh_cnt;
  logic [1:0]              sel;

  // Decode of the current counter value and BCDfreq, ready for the pin registers.
  logic [3:0] digit_nib;
  logic [3:0] enable_d;
  logic [6:0] seg_d;
  logic       blank_d;

  // Pin registers.
  logic [6:0] seg_q;
  logic [3:0] enable_q;
  logic       dp_q;

  assign sel = refresh_cnt[REFRESH_BITS-1:REFRESH_BITS-2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Pick the digit nibble and its anode. Exactly one anode is driven low.
  always_comb begin
    digit_nib = BCDfreq[3:0];
    enable_d  = 4'b1110;
    case (sel)
      2'd0: begin
        digit_nib = BCDfreq[3:0];
        enable_d  = 4'b1110;
      end
      2'd1: begin
        digit_nib = BCDfreq[7:4];
        enable_d  = 4'b1101;
      end
      2'd2: begin
        digit_nib = BCDfreq[11:8];
        enable_d  = 4'b1011;
      end
      default: begin
        digit_nib = BCDfreq[15:12];
        enable_d  = 4'b0111;
      end
    endcase
  end

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit above it is zero.
  // Digit 0 is exempt, so a reading of 0 still shows a single "0".
  always_comb begin
    blank_d = 1'b0;
    case (sel)
      2'd1:    blank_d = (BCDfreq[15:4] == 12'h000);
      2'd2:    blank_d = (BCDfreq[15:8] == 8'h00);
      2'd3:    blank_d = (BCDfreq[15:12] == 4'h0);
      default: blank_d = 1'b0;
    endcase
  end
`else
  // With blanking disabled, every digit is shown, including leading zeros.
  always_comb begin
    blank_d = 1'b0;
  end
`endif

  always_comb begin
    seg_d = decode_seg(digit_nib);
    if (blank_d) begin
      seg_d = SEG_BLANK;
    end
  end

  // The pins load the decode of the pre-increment counter. The first edge
  // after reset is released therefore shows digit 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q    <= SEG_BLANK;
      enable_q <= 4'b1111;
      dp_q     <= 1'b1;
    end else begin
      seg_q    <= seg_d;
      enable_q <= enable_d;
      dp_q     <= 1'b1;
    end
  end

  assign {a, b, c, d, e, f, g} = seg_q;
  assign enable                = enable_q;
  assign dp                    = dp_q;

endmodule

// File: tb/tb_seven_seg_display.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_display
//
// Self-checking bench for seven_seg_display with REFRESH_BITS=4, so each
// digit is lit for 4 clocks. Expected pin values come from a reference model
// that works from the displayed digit index and the BCD value:
//   digit  = (cycles since reset release / 4) % 4
//   anode  = active-low one-hot of digit
//   nibble = (BCDfreq >> 4*digit) % 16
//   segs   = looked up in a 16-entry table
// When SEVSEG_LEADING_ZERO_BLANK_EN is defined, the model also applies
// leading-zero blanking.
// ---------------------------------------------------------------------------
module tb_seven_seg_display;

  localparam int RB   = 4;
  localparam int DWELL = 1 << (RB - 2);

  logic        clk;
  logic        reset;
  logic [15:0] BCDfreq;
  logic        a, b, c, d, e, f, g, dp;
  logic [3:0]  enable;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [6:0] seg_tab [16];

  seven_seg_display #(.REFRESH_BITS(RB)) dut (
    .clk     (clk),
    .reset   (reset),
    .BCDfreq (BCDfreq),
    .a       (a),
    .b       (b),
    .c       (c),
    .d       (d),
    .e       (e),
    .f       (f),
    .g       (g),
    .dp      (dp),
    .enable  (enable)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checker: compares one observed value with the value the bench expects.
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_blank(input string tag);
    check({tag, "_en"},  {12'h0, enable}, 16'h000f);
    check({tag, "_seg"}, {9'h0, a, b, c, d, e, f, g}, 16'h007f);
    check({tag, "_dp"},  {15'h0, dp}, 16'h0001);
  endtask

  // Reference model: the pin values expected after the edge that decodes scan cycle n.
  function automatic logic [10:0] model(input int n, input logic [15:0] bcd);
    int         dig;
    int         nib;
    logic [6:0] seg;
    logic [3:0] en;
    dig = (n / DWELL) % 4;
    nib = (int'(bcd) >> (4 * dig)) % 16;
    seg = seg_tab[nib];
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    if (dig > 0 && (int'(bcd) >> (4 * dig)) == 0) seg = 7'h7f;
`endif
    en = ~(4'b0001 << dig);
    return {en, seg};
  endfunction

  // Driver: one clock edge, then check the pins on the following falling edge.
  task automatic tick();
    logic [10:0] exp;
    exp = model(cyc, BCDfreq);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check("scan_en",  {12'h0, enable}, {12'h0, exp[10:7]});
    check("scan_seg", {9'h0, a, b, c, d, e, f, g}, {9'h0, exp[6:0]});
    check("scan_dp",  {15'h0, dp}, 16'h0001);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int k = 0; k < 4; k++) begin
      // Mostly valid digits, with some invalid nibbles and some leading zeros.
      case ($urandom_range(0, 7))
        0:       v[4*k +: 4] = 4'($urandom_range(10, 15));
        1, 2:    v[4*k +: 4] = 4'h0;
        default: v[4*k +: 4] = 4'($urandom_range(0, 9));
      endcase
    end
    return v;
  endfunction

  logic [15:0] directed [6];

  initial begin
    seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111;
    seg_tab[2] = 7'b0010010; seg_tab[3] = 7'b0000110;
    seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
    seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111;
    seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0000100;
    for (int i = 10; i < 16; i++) seg_tab[i] = 7'b1111110;
    directed[0] = 16'h0000; directed[1] = 16'h0007; directed[2] = 16'h0090;
    directed[3] = 16'h9000; directed[4] = 16'h0A00; directed[5] = 16'h1234;

    // Hold reset with the clock running. The pins must stay blank.
    reset   = 1'b0;
    BCDfreq = 16'h0105;
    repeat (3) begin
      @(negedge clk);
      check_blank("reset_hold");
    end

    // Release reset and check the scan order for 0105 across two full scans.
    reset = 1'b1;
    cyc   = 0;
    repeat (2 * 4 * DWELL) tick();

    // Live update while digit 0 is active. cyc is at a scan boundary here.
    BCDfreq = 16'h0000;
    tick();
    check("live_zero", {9'h0, a, b, c, d, e, f, g}, 16'h0001);
    BCDfreq = 16'h0105;
    tick();
    check("live_five", {9'h0, a, b, c, d, e, f, g}, 16'h0024);

    // Invalid nibble in the tens position, across one full scan.
    BCDfreq = 16'h00A9;
    repeat (4 * DWELL) tick();

    // Directed values, including leading-zero patterns.
    for (int i = 0; i < 6; i++) begin
      BCDfreq = directed[i];
      repeat (4 * DWELL) tick();
    end

    // Random values that change every few clocks.
    for (int i = 0; i < 60; i++) begin
      BCDfreq = rand_bcd();
      repeat ($urandom_range(1, 6)) tick();
    end

    // Asynchronous reset while digit 2 is active.
    while (((cyc / DWELL) % 4) != 2) tick();
    tick();
    check("pre_reset_en", {12'h0, enable}, 16'h000b);
    #2 reset = 1'b0;
    #1 check_blank("async_reset");
    @(posedge clk);
    @(negedge clk);
    check_blank("reset_held");
    reset = 1'b1;
    cyc   = 0;
    tick();
    check("restart_en", {12'h0, enable}, 16'h000e);

    // More random values after the restart.
    for (int i = 0; i < 40; i++) begin
      BCDfreq = rand_bcd();
      repeat ($urandom_range(1, 8)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: make sure the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
